// File: rtl/mat_result_writer.sv
// Result-side writer for C = A x B: buffers MAC results in a small FIFO and
// drains them to result memory in row-major order, pulsing done after N*N writes.
`ifndef ADDR_BITS
`define ADDR_BITS 7
`endif

module mat_result_writer #(
  parameter int N      = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = `ADDR_BITS,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  localparam int NN    = N * N;
  localparam int RC_W  = $clog2(N);
  localparam int CNT_W = $clog2(NN) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] NN_C      = CNT_W'(NN);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(NN - 1);
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(DEPTH);
  localparam logic [RC_W-1:0]  COL_MAX_C = RC_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [DATA_W-1:0]  fifo_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W:0]     count_r;
  logic [CNT_W-1:0]   acc_cnt_r;
  logic [CNT_W-1:0]   wr_cnt_r;
  logic [RC_W-1:0]    row_r;
  logic [RC_W-1:0]    col_r;
  logic               push_s;
  logic               pop_s;
  logic               clear_s;

  assign clear_s   = (state_r == IDLE) && start;
  assign in_ready  = (state_r == RUN) && (count_r < DEPTH_C) && (acc_cnt_r < NN_C);
  assign mem_we    = (count_r != {(PTR_W + 1){1'b0}});
  assign mem_wdata = mem_we ? fifo_r[rd_ptr_r] : {DATA_W{1'b0}};
  // N is a power of two, so row*N + col is just the concatenation.
  assign mem_addr  = ADDR_W'({row_r, col_r});
  assign push_s    = in_valid && in_ready;
  assign pop_s     = mem_we && mem_ready;
  assign busy      = (state_r == RUN);
  assign done      = (state_r == DONE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = IDLE;
      end
      RUN: begin
        if (pop_s && (wr_cnt_r == LAST_C)) state_nxt_s = DONE;
        else                               state_nxt_s = RUN;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FIFO storage, pointers and row/col/accept/write counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) fifo_r[i] <= {DATA_W{1'b0}};
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {(PTR_W + 1){1'b0}};
      acc_cnt_r <= {CNT_W{1'b0}};
      wr_cnt_r  <= {CNT_W{1'b0}};
      row_r     <= {RC_W{1'b0}};
      col_r     <= {RC_W{1'b0}};
    end else if (clear_s) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {(PTR_W + 1){1'b0}};
      acc_cnt_r <= {CNT_W{1'b0}};
      wr_cnt_r  <= {CNT_W{1'b0}};
      row_r     <= {RC_W{1'b0}};
      col_r     <= {RC_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= in_data;
        wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
        acc_cnt_r        <= acc_cnt_r + CNT_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        wr_cnt_r <= wr_cnt_r + CNT_W'(1);
        col_r    <= col_r + RC_W'(1);
        if (col_r == COL_MAX_C) row_r <= row_r + RC_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
